color_scan_sequencer: RTL

COLOR_SCAN_SEQUENCER -- requirements
Module: color_scan_sequencer

---
 rtl/color_pkg.sv | 23 ++
 rtl/color_rr_pick.sv | 25 ++
 rtl/color_scan_sequencer.sv | 137 +++++++++++++
 3 files changed

// File: rtl/color_pkg.sv
// Shared types for the color scan sequencer: color codes, scheduler states
// and the default active-video geometry.
package color_pkg;

    typedef enum logic [1:0] {
        RED    = 2'd0,
        GREEN  = 2'd1,
        BLUE   = 2'd2,
        YELLOW = 2'd3
    } color_t;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SELECT = 3'd1,
        ARM    = 3'd2,
        SCAN   = 3'd3,
        OUTPUT = 3'd4
    } state_t;

    localparam int H_ACTIVE_DEFAULT = 1280;
    localparam int V_ACTIVE_DEFAULT = 720;

endpackage

// File: rtl/color_rr_pick.sv
// Round-robin color picker: first set mask bit strictly after 'last',
// wrapping 3->0, so 'last' itself is only chosen when it is the sole bit.
module color_rr_pick (
    input  logic [3:0] mask,
    input  logic [1:0] last,
    output logic [1:0] next,
    output logic       any
);

    always_comb begin
        logic [1:0] cand;
        next = last;
        cand = last;
        // Walk farthest-first so the nearest set bit is the final winner.
        for (int i = 4; i >= 1; i--) begin
            cand = last + 2'(i);
            if (mask[cand]) begin
                next = cand;
            end
        end
    end

    assign any = |mask;

endmodule

// File: rtl/color_scan_sequencer.sv
// Schedules per-color detector scans frame by frame and hands each centroid
// (or a miss) to a consumer over a valid/ready result port.
module color_scan_sequencer
    import color_pkg::*;
#(
    parameter int TIMEOUT_FRAMES = 2,
    parameter int H_ACTIVE       = H_ACTIVE_DEFAULT,
    parameter int V_ACTIVE       = V_ACTIVE_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [3:0]  color_mask,
    input  logic        frame_start,
    input  logic        det_ready,
    input  logic [31:0] det_coord,
    output logic        det_enable,
    output logic [1:0]  det_color,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [1:0]  res_color,
    output logic [15:0] res_x,
    output logic [15:0] res_y,
    output logic        res_miss,
    output logic        busy,
    output state_t      dbg_state
);

    // Result port: res_valid and all res_* fields stay stable while
    // res_valid=1 and res_ready=0; a transfer happens on a clock edge where
    // both are high, and res_valid drops on the following cycle.

    state_t      state, state_next;
    logic [1:0]  last_color;
    logic [1:0]  pick_color;
    logic        mask_any;
    logic [15:0] frame_cnt;
    logic        load_color, take_hit, take_miss, cnt_inc, commit;
    logic        hit_out_of_range;

    color_rr_pick u_pick (
        .mask (color_mask),
        .last (last_color),
        .next (pick_color),
        .any  (mask_any)
    );

    assign hit_out_of_range = (det_coord[31:16] >= 16'(H_ACTIVE)) ||
                              (det_coord[15:0]  >= 16'(V_ACTIVE));

    always_comb begin
        state_next = state;
        load_color = 1'b0;
        take_hit   = 1'b0;
        take_miss  = 1'b0;
        cnt_inc    = 1'b0;
        commit     = 1'b0;
        det_enable = 1'b0;
        res_valid  = 1'b0;
        busy       = (state != IDLE);
        case (state)
            IDLE: begin
                if (enable && mask_any) state_next = SELECT;
            end
            SELECT: begin
                if (!enable || !mask_any) begin
                    state_next = IDLE;
                end else begin
                    load_color = 1'b1;
                    state_next = ARM;
                end
            end
            ARM: begin
                if (!enable)          state_next = IDLE;
                else if (frame_start) state_next = SCAN;
            end
            SCAN: begin
                det_enable = 1'b1;
                // Abort beats a result; a result beats the timeout frame.
                if (!enable) begin
                    state_next = IDLE;
                end else if (det_ready) begin
                    take_hit   = 1'b1;
                    state_next = OUTPUT;
                end else if (frame_start) begin
                    if (frame_cnt == 16'(TIMEOUT_FRAMES - 1)) begin
                        take_miss  = 1'b1;
                        state_next = OUTPUT;
                    end else begin
                        cnt_inc = 1'b1;
                    end
                end
            end
            OUTPUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    commit     = 1'b1;
                    state_next = (enable && mask_any) ? SELECT : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_color <= YELLOW;
            det_color  <= RED;
            frame_cnt  <= '0;
            res_color  <= '0;
            res_x      <= '0;
            res_y      <= '0;
            res_miss   <= 1'b0;
        end else begin
            state <= state_next;
            if (load_color) det_color <= pick_color;
            if (commit)     last_color <= res_color;
            if (state != SCAN) frame_cnt <= '0;
            else if (cnt_inc)  frame_cnt <= frame_cnt + 16'd1;
            if (take_hit) begin
                res_color <= det_color;
                res_x     <= det_coord[31:16];
                res_y     <= det_coord[15:0];
                res_miss  <= hit_out_of_range;
            end else if (take_miss) begin
                res_color <= det_color;
                res_x     <= '0;
                res_y     <= '0;
                res_miss  <= 1'b1;
            end
        end
    end

    assign dbg_state = state;

endmodule
